// File: rtl/proj1_alu_seq.sv
// rtl/proj1_alu_seq.sv - instruction sequencer and 16x8 register file feeding the proj1 ALU
// Optional debug read port (dbg_addr/dbg_data) is built only when PROJ1_SEQ_DBG_EN is defined.
module proj1_alu_seq #(
    parameter int ALU_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [7:0]  instr_op,
    input  logic [3:0]  instr_rd,
    input  logic [3:0]  instr_rr,
    output logic [7:0]  alu_rd,
    output logic [7:0]  alu_rr,
    output logic [7:0]  alu_op,
    output logic        alu_ci,
    input  logic [15:0] alu_data,
    input  logic        alu_co,
    input  logic        alu_no,
    input  logic        alu_zo,
    output logic [2:0]  sreg,
    output logic        done
`ifdef PROJ1_SEQ_DBG_EN
    ,
    input  logic [3:0]  dbg_addr,
    output logic [7:0]  dbg_data
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IMM,
        S_ISSUE,
        S_WAIT,
        S_WB
    } state_t;

    typedef enum logic [2:0] {
        C_SHIFT,
        C_MUL,
        C_LOGIC,
        C_NEG,
        C_ADDSUB,
        C_LDI,
        C_NOP
    } class_t;

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    function automatic class_t classify(input logic [7:0] op);
        class_t c;
        c = C_NOP;
        if (op[7:6] == 2'b11)                          c = C_ADDSUB;
        else if (op[7:4] == 4'b0000)                   c = C_SHIFT;
        else if (op[7:4] == 4'b0100)                   c = C_MUL;
        else if (op[7:4] == 4'b0011)                   c = C_LDI;
        else if (op[7:4] == 4'b1000 || op[7:4] == 4'b1001 || op[7:4] == 4'b1010)
                                                       c = C_LOGIC;
        else if (op[7:4] == 4'b1011 && op[1:0] == 2'b00)
                                                       c = C_NEG;
        return c;
    endfunction

    state_t        state_q, state_d;
    logic [7:0]    op_q, op_d;
    logic [3:0]    rd_q, rd_d;
    logic [3:0]    rr_q, rr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    alu_rd_q, alu_rd_d;
    logic [7:0]    alu_rr_q, alu_rr_d;
    logic [7:0]    alu_op_q, alu_op_d;
    logic          alu_ci_q, alu_ci_d;
    logic [2:0]    sreg_q, sreg_d;
    logic          done_q, done_d;
    logic [7:0]    regs_q [16];

    logic          rf_we;
    logic          mul_we;
    logic [3:0]    rf_waddr;
    logic [7:0]    rf_wdata;
    class_t        in_cls;
    class_t        cur_cls;

    always_comb begin
        in_cls   = classify(instr_op);
        cur_cls  = classify(op_q);
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        alu_rd_d = alu_rd_q;
        alu_rr_d = alu_rr_q;
        alu_op_d = alu_op_q;
        alu_ci_d = alu_ci_q;
        sreg_d   = sreg_q;
        done_d   = 1'b0;
        rf_we    = 1'b0;
        mul_we   = 1'b0;
        rf_waddr = rd_q;
        rf_wdata = alu_data[7:0];

        unique case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d = instr_op;
                    rd_d = instr_rd;
                    rr_d = instr_rr;
                    if (in_cls == C_LDI || in_cls == C_NOP) begin
                        state_d = S_IMM;
                    end else begin
                        // Operands are latched here so they stay frozen until the next ALU accept.
                        state_d  = S_ISSUE;
                        alu_rd_d = regs_q[instr_rd];
                        alu_rr_d = regs_q[instr_rr];
                        alu_op_d = instr_op;
                        alu_ci_d = sreg_q[0];
                    end
                end
            end
            S_IMM: begin
                if (cur_cls == C_LDI) begin
                    rf_we    = 1'b1;
                    rf_wdata = {op_q[3:0], rr_q};
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_ISSUE: begin
                cnt_d   = CW'(ALU_LAT - 1);
                state_d = (ALU_LAT == 1) ? S_WB : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = S_WB;
            end
            S_WB: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                case (cur_cls)
                    C_MUL: begin
                        mul_we = 1'b1;
                        sreg_d = {alu_zo, sreg_q[1], alu_co};
                    end
                    C_LOGIC, C_NEG: begin
                        // ALU flags are not trusted for these ops; derive Z/N from the result.
                        rf_we  = 1'b1;
                        sreg_d = {(alu_data[7:0] == 8'h00), alu_data[7], sreg_q[0]};
                    end
                    default: begin
                        rf_we  = 1'b1;
                        sreg_d = {alu_zo, alu_no, alu_co};
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= 8'h00;
            rd_q     <= 4'h0;
            rr_q     <= 4'h0;
            cnt_q    <= '0;
            alu_rd_q <= 8'h00;
            alu_rr_q <= 8'h00;
            alu_op_q <= 8'h00;
            alu_ci_q <= 1'b0;
            sreg_q   <= 3'b000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            alu_rd_q <= alu_rd_d;
            alu_rr_q <= alu_rr_d;
            alu_op_q <= alu_op_d;
            alu_ci_q <= alu_ci_d;
            sreg_q   <= sreg_d;
            done_q   <= done_d;
        end
    end

    // MUL owns R0/R1 outright, so it wins over any rd-indexed write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
        end else if (mul_we) begin
            regs_q[0] <= alu_data[7:0];
            regs_q[1] <= alu_data[15:8];
        end else if (rf_we) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign alu_rd      = alu_rd_q;
    assign alu_rr      = alu_rr_q;
    assign alu_op      = alu_op_q;
    assign alu_ci      = alu_ci_q;
    assign sreg        = sreg_q;
    assign done        = done_q;

`ifdef PROJ1_SEQ_DBG_EN
    assign dbg_data = regs_q[dbg_addr];
`endif

endmodule

// File: tb/tb_proj1_alu_seq.sv
// tb/tb_proj1_alu_seq.sv - scoreboard bench for proj1_alu_seq with a latency-accurate ALU model
module tb_proj1_alu_seq;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_op;
    logic [3:0]  instr_rd;
    logic [3:0]  instr_rr;
    logic [7:0]  alu_rd;
    logic [7:0]  alu_rr;
    logic [7:0]  alu_op;
    logic        alu_ci;
    logic [15:0] alu_data;
    logic        alu_co;
    logic        alu_no;
    logic        alu_zo;
    logic [2:0]  sreg;
    logic        done;
`ifdef PROJ1_SEQ_DBG_EN
    logic [3:0]  dbg_addr;
    logic [7:0]  dbg_data;
`endif

    proj1_alu_seq #(.ALU_LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rr    (instr_rr),
        .alu_rd      (alu_rd),
        .alu_rr      (alu_rr),
        .alu_op      (alu_op),
        .alu_ci      (alu_ci),
        .alu_data    (alu_data),
        .alu_co      (alu_co),
        .alu_no      (alu_no),
        .alu_zo      (alu_zo),
        .sreg        (sreg),
        .done        (done)
`ifdef PROJ1_SEQ_DBG_EN
        ,
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tot = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Result word is {co, no, zo, data[15:0]}; logic/NEG flags are deliberately wrong.
    function automatic logic [18:0] alu_fn(input logic [7:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic ci);
        logic [15:0] d;
        logic [8:0]  s;
        logic        co, no, zo;
        d = 16'h0; co = 1'b0; no = 1'b0; zo = 1'b0;
        if (op[7:4] == 4'h0) begin
            d  = {8'h00, a[6:0], ci};
            co = a[7]; zo = (d[7:0] == 8'h00); no = d[7];
        end else if (op[7:4] == 4'h4) begin
            d  = 16'(a) * 16'(b);
            co = d[15]; zo = (d == 16'h0); no = d[15];
        end else if (op[7:6] == 2'b11) begin
            if (op[5]) s = {1'b0, a} - {1'b0, b} - {8'h00, ci};
            else       s = {1'b0, a} + {1'b0, b} + {8'h00, ci};
            d  = {8'h00, s[7:0]};
            co = s[8]; zo = (s[7:0] == 8'h00); no = s[7];
        end else begin
            case (op[7:4])
                4'h8:    d = {8'h00, a & b};
                4'h9:    d = {8'h00, a | b};
                4'hA:    d = {8'h00, a ^ b};
                4'hB:    d = {8'h00, 8'(8'h00 - a)};
                default: d = {b, a};
            endcase
            zo = (d[7:0] != 8'h00); no = ~d[7]; co = ~ci;
        end
        return {co, no, zo, d};
    endfunction

    logic [18:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= alu_fn(alu_op, alu_rd, alu_rr, alu_ci);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign {alu_co, alu_no, alu_zo, alu_data} = pipe[LAT-1];

    // 0 NOP, 1 LDI, 2 shift/add-sub, 3 MUL, 4 logic/NEG
    function automatic int cls_of(input logic [7:0] op);
        if (op[7:4] == 4'h3) return 1;
        if (op[7:4] == 4'h0 || op[7:6] == 2'b11) return 2;
        if (op[7:4] == 4'h4) return 3;
        if (op[7:4] == 4'h8 || op[7:4] == 4'h9 || op[7:4] == 4'hA) return 4;
        if (op[7:4] == 4'hB && op[1:0] == 2'b00) return 4;
        return 0;
    endfunction

    typedef struct {
        logic       is_alu;
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [2:0] sreg;
        int         done_cyc;
        logic [3:0] idx0;
        logic [3:0] idx1;
        logic [7:0] val0;
        logic [7:0] val1;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mr [16];
    logic       mz, mn, mc;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mr[i] = 8'h00;
        mz = 1'b0; mn = 1'b0; mc = 1'b0;
        sb.delete();
    endtask

    task automatic model_push(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rr);
        exp_t        e;
        int          c;
        logic [18:0] r;
        c        = cls_of(op);
        e.op     = op;
        e.is_alu = (c >= 2);
        e.a      = mr[rd];
        e.b      = mr[rr];
        e.ci     = mc;
        e.done_cyc = cyc + 2 + (e.is_alu ? LAT : 0);
        if (c == 1) begin
            mr[rd] = {op[3:0], rr};
        end else if (c >= 2) begin
            r = alu_fn(op, e.a, e.b, e.ci);
            if (c == 2) begin
                mr[rd] = r[7:0]; mz = r[16]; mn = r[17]; mc = r[18];
            end else if (c == 3) begin
                mr[0] = r[7:0]; mr[1] = r[15:8]; mz = r[16]; mc = r[18];
            end else begin
                mr[rd] = r[7:0]; mz = (r[7:0] == 8'h00); mn = r[7];
            end
        end
        e.sreg = {mz, mn, mc};
        e.idx0 = (c == 3) ? 4'd0 : rd;
        e.idx1 = (c == 3) ? 4'd1 : rr;
        e.val0 = mr[e.idx0];
        e.val1 = mr[e.idx1];
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    tot++; bad++;
                    $display("FAIL done_unexpected act=1 exp=0");
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("ready_at_done", instr_ready, 1);
                    chk("sreg", sreg, e.sreg);
                    if (e.is_alu) begin
                        chk("alu_op", alu_op, e.op);
                        chk("alu_rd", alu_rd, e.a);
                        chk("alu_rr", alu_rr, e.b);
                        chk("alu_ci", alu_ci, e.ci);
                    end
`ifdef PROJ1_SEQ_DBG_EN
                    dbg_addr = e.idx0;
                    #1 chk("reg_a", dbg_data, e.val0);
                    dbg_addr = e.idx1;
                    #1 chk("reg_b", dbg_data, e.val1);
`endif
                end
            end
        end
    end

    task automatic issue(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rr,
                         input bit push = 1'b1);
        int n = 0;
        @(negedge clk);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rr = rr;
        while (!instr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 0, 1);
            instr_valid = 1'b0;
            return;
        end
        if (push) model_push(op, rd, rr);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_op = 8'($urandom); instr_rd = 4'($urandom); instr_rr = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        @(negedge clk);
    endtask

`ifdef PROJ1_SEQ_DBG_EN
    task automatic chk_reg(input logic [3:0] idx, input logic [7:0] val);
        dbg_addr = idx;
        #1 chk($sformatf("R%0d", idx), dbg_data, val);
    endtask
`endif

    initial begin
        int acc;
        rst = 1'b1; instr_valid = 1'b0; instr_op = 8'h00; instr_rd = 4'h0; instr_rr = 4'h0;
`ifdef PROJ1_SEQ_DBG_EN
        dbg_addr = 4'h0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready", instr_ready, 1);
        chk("rst_alu_rd", alu_rd, 0);
        chk("rst_alu_rr", alu_rr, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_ci", alu_ci, 0);
        chk("rst_sreg", sreg, 0);
        chk("rst_done", done, 0);
`ifdef PROJ1_SEQ_DBG_EN
        #1 chk("rst_dbg", dbg_data, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        issue(8'h3A, 4'd5, 4'd7);
        drain();
        chk("ldi_sreg", sreg, 3'b000);
`ifdef PROJ1_SEQ_DBG_EN
        chk_reg(4'd5, 8'hA7);
`endif

        issue(8'h3F, 4'd7, 4'hF);
        issue(8'h30, 4'd8, 4'h1);
        issue(8'hC0, 4'd7, 4'd8);
        issue(8'h30, 4'd1, 4'hF);
        issue(8'h3F, 4'd2, 4'h0);
        issue(8'h80, 4'd1, 4'd2);
        drain();
        chk("and_sreg", sreg, 3'b101);
`ifdef PROJ1_SEQ_DBG_EN
        chk_reg(4'd1, 8'h00);
`endif

        issue(8'h31, 4'd3, 4'h0);
        issue(8'h32, 4'd4, 4'h0);
        issue(8'h40, 4'd3, 4'd4);
        drain();
        chk("mul_sreg", sreg, 3'b000);
`ifdef PROJ1_SEQ_DBG_EN
        chk_reg(4'd0, 8'h00);
        chk_reg(4'd1, 8'h02);
        chk_reg(4'd3, 8'h10);
        chk_reg(4'd4, 8'h20);
`endif

        issue(8'h3F, 4'd7, 4'hF);
        issue(8'hC0, 4'd7, 4'd8);
        issue(8'h38, 4'd6, 4'h0);
        issue(8'h02, 4'd6, 4'd0);
        drain();
        chk("rol_ci", alu_ci, 1);
        chk("rol_sreg", sreg, 3'b001);
`ifdef PROJ1_SEQ_DBG_EN
        chk_reg(4'd6, 8'h01);
`endif

        // Reset during WAIT of an ADD must abort without writeback.
        issue(8'h33, 4'd2, 4'h3);
        issue(8'h34, 4'd9, 4'h4);
        drain();
        issue(8'hC0, 4'd2, 4'd9, 1'b0);
        @(negedge clk);
        chk("abort_issue_rd", alu_rd, mr[2]);
        chk("abort_issue_rr", alu_rr, mr[9]);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_sreg", sreg, 0);
        chk("abort_ready", instr_ready, 1);
        chk("abort_alu_op", alu_op, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", instr_ready, 1);
        chk("post_rst_sreg", sreg, 0);
`ifdef PROJ1_SEQ_DBG_EN
        for (int i = 0; i < 16; i++) chk_reg(4'(i), 8'h00);
`endif
        @(negedge clk);

        // NOP with valid held high: one accept per IDLE visit.
        acc = 0;
        instr_valid = 1'b1; instr_op = 8'h50; instr_rd = 4'd3; instr_rr = 4'd4;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (instr_ready) begin
                model_push(8'h50, 4'd3, 4'd4);
                acc++;
            end
            @(posedge clk);
        end
        #1 instr_valid = 1'b0;
        chk("nop_accepts", acc, 3);
        drain();

        for (int k = 0; k < 200; k++) begin
            issue(8'($urandom), 4'($urandom), 4'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
